// File: rtl/bus_master_arbiter_if.sv
// Bundle of the two requester ports and the shared BUS master port seen by bus_master_arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters plus BUS.
interface bus_master_arbiter_if;
  logic        m0_read;
  logic        m0_write;
  logic [31:0] m0_address;
  logic [31:0] m0_write_data;
  logic [2:0]  m0_option;
  logic [31:0] m0_read_data;
  logic        m0_response;

  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_address;
  logic [31:0] m1_write_data;
  logic [2:0]  m1_option;
  logic [31:0] m1_read_data;
  logic        m1_response;

  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [2:0]  option;
  logic [31:0] read_data;
  logic        response;

  logic [1:0]  owner;
  logic        bus_error;

  modport master (
    input  m0_read, m0_write, m0_address, m0_write_data, m0_option,
    output m0_read_data, m0_response,
    input  m1_read, m1_write, m1_address, m1_write_data, m1_option,
    output m1_read_data, m1_response,
    output read, write, address, write_data, option,
    input  read_data, response,
    output owner, bus_error
  );

  modport slave (
    output m0_read, m0_write, m0_address, m0_write_data, m0_option,
    input  m0_read_data, m0_response,
    output m1_read, m1_write, m1_address, m1_write_data, m1_option,
    input  m1_read_data, m1_response,
    input  read, write, address, write_data, option,
    output read_data, response,
    input  owner, bus_error
  );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing the SoC bus master port between M0 (core) and M1 (DMA/debug),
// holding the grant for a whole transaction and terminating hung ones with an error response.
module bus_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
  input logic                  clk,
  input logic                  reset,
  bus_master_arbiter_if.master bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    owner;
  logic          last;     // 1: M1 was served last, so M0 wins the next tie
  logic [TW-1:0] timer;

  logic req0;
  logic req1;
  logic granted;
  logic sel_m1;
  logic timeout;

  assign req0 = bus.m0_read | bus.m0_write;
  assign req1 = bus.m1_read | bus.m1_write;

  always_comb begin
    granted = (state == GRANT);
    sel_m1  = (owner == 2'b10);
    timeout = granted && (TIMEOUT_CYCLES != 0) && (timer == TIMER_LIMIT) && !bus.response;

    bus.read         = 1'b0;
    bus.write        = 1'b0;
    bus.address      = '0;
    bus.write_data   = '0;
    bus.option       = '0;
    bus.m0_response  = 1'b0;
    bus.m0_read_data = '0;
    bus.m1_response  = 1'b0;
    bus.m1_read_data = '0;
    bus.bus_error    = timeout;
    bus.owner        = owner;

    if (granted) begin
      if (sel_m1) begin
        bus.read         = bus.m1_read & ~timeout;
        bus.write        = bus.m1_write & ~timeout;
        bus.address      = bus.m1_address;
        bus.write_data   = bus.m1_write_data;
        bus.option       = bus.m1_option;
        bus.m1_response  = bus.response | timeout;
        bus.m1_read_data = timeout ? ERROR_DATA : bus.read_data;
      end else begin
        bus.read         = bus.m0_read & ~timeout;
        bus.write        = bus.m0_write & ~timeout;
        bus.address      = bus.m0_address;
        bus.write_data   = bus.m0_write_data;
        bus.option       = bus.m0_option;
        bus.m0_response  = bus.response | timeout;
        bus.m0_read_data = timeout ? ERROR_DATA : bus.read_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 2'b00;
      last  <= 1'b1;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (req0 && (!req1 || last)) begin
            owner <= 2'b01;
            state <= GRANT;
          end else if (req1) begin
            owner <= 2'b10;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (bus.response || timeout) begin
            last  <= (owner == 2'b10);
            timer <= '0;
            state <= RELEASE;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        RELEASE: begin
          owner <= 2'b00;
          state <= IDLE;
        end
        default: begin
          owner <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model.
module tb_bus_master_arbiter;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  bus_master_arbiter_if bif ();

  bus_master_arbiter #(.TIMEOUT_CYCLES(TO), .ERROR_DATA(ERR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bif.m0_read = 1'b0; bif.m0_write = 1'b0; bif.m0_address = '0; bif.m0_write_data = '0; bif.m0_option = '0;
    bif.m1_read = 1'b0; bif.m1_write = 1'b0; bif.m1_address = '0; bif.m1_write_data = '0; bif.m1_option = '0;
    bif.read_data = '0; bif.response = 1'b0;
  endtask

  // Caller has raised response in a GRANT cycle; walk through RELEASE back to IDLE.
  task automatic close_txn();
    bif.m0_read = 1'b0; bif.m0_write = 1'b0; bif.m1_read = 1'b0; bif.m1_write = 1'b0;
    step();
    bif.response = 1'b0; bif.read_data = '0;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    settle();
    checks++; if (bif.owner !== 2'b00) begin failures++; $display("FAIL reset_owner got=%0h exp=0", bif.owner); end
    checks++; if ({bif.read, bif.write} !== 2'b00) begin failures++; $display("FAIL reset_rw got=%0b exp=00", {bif.read, bif.write}); end
    checks++; if (bif.bus_error !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bif.bus_error); end
    checks++; if ({bif.m0_response, bif.m1_response} !== 2'b00) begin failures++; $display("FAIL reset_resp got=%0b exp=00", {bif.m0_response, bif.m1_response}); end
  endtask

  task automatic test_single_read();
    step();
    bif.m0_read = 1'b1; bif.m0_address = 32'h0000_0100; bif.m0_option = 3'b101;
    settle();
    checks++; if (bif.read !== 1'b0) begin failures++; $display("FAIL t1_latency got=%0b exp=0", bif.read); end
    step();
    settle();
    checks++; if ({bif.read, bif.address, bif.option} !== {1'b1, 32'h0000_0100, 3'b101}) begin
      failures++; $display("FAIL t1_strobe got=%0b/%0h/%0h exp=1/100/5", bif.read, bif.address, bif.option); end
    checks++; if (bif.owner !== 2'b01) begin failures++; $display("FAIL t1_owner got=%0h exp=1", bif.owner); end
    step(); step(); step();
    bif.response = 1'b1; bif.read_data = 32'h1234_5678;
    settle();
    checks++; if ({bif.m0_response, bif.m0_read_data} !== {1'b1, 32'h1234_5678}) begin
      failures++; $display("FAIL t1_resp got=%0b/%0h exp=1/12345678", bif.m0_response, bif.m0_read_data); end
    checks++; if (bif.m1_response !== 1'b0) begin failures++; $display("FAIL t1_m1resp got=%0b exp=0", bif.m1_response); end
    bif.m0_read = 1'b0;
    step();
    bif.response = 1'b0; bif.read_data = '0;
    settle();
    checks++; if ({bif.owner, bif.read, bif.m0_response} !== {2'b01, 1'b0, 1'b0}) begin
      failures++; $display("FAIL t1_release got=%0h/%0b/%0b exp=1/0/0", bif.owner, bif.read, bif.m0_response); end
    step();
    checks++; if (bif.owner !== 2'b00) begin failures++; $display("FAIL t1_idle_owner got=%0h exp=0", bif.owner); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; step(); reset = 1'b0;
    bif.m0_read = 1'b1; bif.m0_address = 32'hA000_0000;
    bif.m1_write = 1'b1; bif.m1_address = 32'hB000_0004; bif.m1_write_data = 32'h5555_AAAA; bif.m1_option = 3'b010;
    step();
    settle();
    checks++; if ({bif.owner, bif.read, bif.write, bif.address} !== {2'b01, 1'b1, 1'b0, 32'hA000_0000}) begin
      failures++; $display("FAIL t2_first got=%0h/%0b%0b/%0h exp=1/10/a0000000", bif.owner, bif.read, bif.write, bif.address); end
    bif.response = 1'b1; bif.read_data = 32'h0BAD_F00D;
    settle();
    checks++; if ({bif.m0_response, bif.m1_response, bif.m1_read_data} !== {1'b1, 1'b0, 32'h0}) begin
      failures++; $display("FAIL t2_m0resp got=%0b%0b/%0h exp=10/0", bif.m0_response, bif.m1_response, bif.m1_read_data); end
    bif.m0_read = 1'b0;
    step();
    bif.response = 1'b0; bif.read_data = '0;
    step(); step();
    settle();
    checks++; if ({bif.owner, bif.write, bif.read, bif.address, bif.write_data, bif.option} !==
                  {2'b10, 1'b1, 1'b0, 32'hB000_0004, 32'h5555_AAAA, 3'b010}) begin
      failures++; $display("FAIL t2_second got=%0h/%0b%0b/%0h/%0h/%0h exp=2/10/b0000004/5555aaaa/2",
                           bif.owner, bif.write, bif.read, bif.address, bif.write_data, bif.option); end
    bif.response = 1'b1;
    settle();
    checks++; if ({bif.m1_response, bif.m0_response} !== 2'b10) begin
      failures++; $display("FAIL t2_m1resp got=%0b%0b exp=10", bif.m1_response, bif.m0_response); end
    bif.m1_write = 1'b0;
    step();
    bif.response = 1'b0;
    step();
    bif.m0_read = 1'b1; bif.m1_read = 1'b1;
    step();
    settle();
    checks++; if (bif.owner !== 2'b01) begin failures++; $display("FAIL t2_alternate got=%0h exp=1", bif.owner); end
    bif.response = 1'b1;
    close_txn();
  endtask

  task automatic test_timeout();
    bif.m0_read = 1'b1; bif.m0_address = 32'h0000_0F00;
    step();
    for (int unsigned i = 0; i < TO; i++) begin
      settle();
      checks++; if ({bif.read, bif.bus_error, bif.m0_response} !== 3'b100) begin
        failures++; $display("FAIL t3_wait%0d got=%0b%0b%0b exp=100", i, bif.read, bif.bus_error, bif.m0_response); end
      step();
    end
    settle();
    checks++; if ({bif.read, bif.m0_response, bif.m0_read_data, bif.bus_error} !== {1'b0, 1'b1, ERR, 1'b1}) begin
      failures++; $display("FAIL t3_timeout got=%0b/%0b/%0h/%0b exp=0/1/deadbeef/1", bif.read, bif.m0_response, bif.m0_read_data, bif.bus_error); end
    bif.m0_read = 1'b0;
    step();
    checks++; if ({bif.bus_error, bif.m0_response, bif.owner} !== {1'b0, 1'b0, 2'b01}) begin
      failures++; $display("FAIL t3_release got=%0b/%0b/%0h exp=0/0/1", bif.bus_error, bif.m0_response, bif.owner); end
    step();
  endtask

  task automatic test_timeout_race();
    bif.m0_read = 1'b1;
    step();
    for (int unsigned i = 0; i < TO; i++) step();
    bif.response = 1'b1; bif.read_data = 32'hCAFE_F00D;
    settle();
    checks++; if ({bif.read, bif.m0_response, bif.m0_read_data, bif.bus_error} !== {1'b1, 1'b1, 32'hCAFE_F00D, 1'b0}) begin
      failures++; $display("FAIL t4_race got=%0b/%0b/%0h/%0b exp=1/1/cafef00d/0", bif.read, bif.m0_response, bif.m0_read_data, bif.bus_error); end
    close_txn();
  endtask

  task automatic test_reset_mid_grant();
    bif.m1_read = 1'b1; bif.m1_address = 32'h0000_0040;
    step();
    settle();
    checks++; if ({bif.owner, bif.read} !== {2'b10, 1'b1}) begin
      failures++; $display("FAIL t5_grant got=%0h/%0b exp=2/1", bif.owner, bif.read); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    checks++; if ({bif.owner, bif.read, bif.write} !== 4'b0000) begin
      failures++; $display("FAIL t5_abandon got=%0h/%0b%0b exp=0/00", bif.owner, bif.read, bif.write); end
    bif.m0_read = 1'b1;
    step();
    settle();
    checks++; if (bif.owner !== 2'b01) begin failures++; $display("FAIL t5_tie got=%0h exp=1", bif.owner); end
    bif.response = 1'b1;
    close_txn();
  endtask

  task automatic test_back_to_back();
    bif.m0_read = 1'b1; bif.m0_address = 32'h0000_1000;
    step();
    bif.response = 1'b1; bif.read_data = 32'h1111_1111;
    settle();
    checks++; if (bif.m0_response !== 1'b1) begin failures++; $display("FAIL t6_first got=%0b exp=1", bif.m0_response); end
    bif.m0_address = 32'h0000_2000;
    step();
    bif.response = 1'b0; bif.read_data = '0;
    settle();
    checks++; if ({bif.read, bif.m0_response, bif.owner} !== {1'b0, 1'b0, 2'b01}) begin
      failures++; $display("FAIL t6_release got=%0b/%0b/%0h exp=0/0/1", bif.read, bif.m0_response, bif.owner); end
    step();
    checks++; if ({bif.read, bif.owner} !== {1'b0, 2'b00}) begin
      failures++; $display("FAIL t6_idle got=%0b/%0h exp=0/0", bif.read, bif.owner); end
    step();
    checks++; if ({bif.read, bif.address, bif.owner, bif.m0_response} !== {1'b1, 32'h0000_2000, 2'b01, 1'b0}) begin
      failures++; $display("FAIL t6_second got=%0b/%0h/%0h/%0b exp=1/2000/1/0", bif.read, bif.address, bif.owner, bif.m0_response); end
    bif.response = 1'b1;
    close_txn();
  endtask

  // Reference model: who holds the bus, how long it has waited, who is preferred on a tie.
  int          holder;  // 0 none, 1 M0, 2 M1
  int          phase;   // 0 free, 1 transaction in flight, 2 cool-down cycle
  int          age;
  int          prefer;
  bit          active[2];
  logic [1:0]  rw[2];
  logic [31:0] maddr[2];
  logic [31:0] mwdata[2];
  logic [2:0]  mopt[2];

  task automatic new_txn(input int i);
    active[i] = 1'b1;
    rw[i]     = 2'($urandom_range(1, 3));
    maddr[i]  = $urandom;
    mwdata[i] = $urandom;
    mopt[i]   = 3'($urandom_range(0, 7));
  endtask

  task automatic drive_masters();
    bif.m0_read = active[0] & rw[0][1]; bif.m0_write = active[0] & rw[0][0];
    bif.m0_address = maddr[0]; bif.m0_write_data = mwdata[0]; bif.m0_option = mopt[0];
    bif.m1_read = active[1] & rw[1][1]; bif.m1_write = active[1] & rw[1][0];
    bif.m1_address = maddr[1]; bif.m1_write_data = mwdata[1]; bif.m1_option = mopt[1];
  endtask

  task automatic test_random();
    logic [68:0] exp_bus;
    logic [32:0] exp_m[2];
    bit          serving, to, resp_seen;
    int          hi;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin active[i] = 1'b0; rw[i] = '0; maddr[i] = '0; mwdata[i] = '0; mopt[i] = '0; end
    reset = 1'b1; step(); reset = 1'b0;
    holder = 0; phase = 0; age = 0; prefer = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < 2; i++) if (!active[i] && $urandom_range(0, 2) == 0) new_txn(i);
      drive_masters();
      bif.response  = ($urandom_range(0, 3) == 0);
      bif.read_data = $urandom;
      settle();
      serving = (phase == 1);
      hi      = (holder == 2) ? 1 : 0;
      to      = serving && (age == int'(TO)) && !bif.response;
      exp_bus = '0;
      if (serving)
        exp_bus = {active[hi] & rw[hi][1] & ~to, active[hi] & rw[hi][0] & ~to, maddr[hi], mwdata[hi], mopt[hi]};
      for (int i = 0; i < 2; i++)
        exp_m[i] = (serving && hi == i) ? {bif.response | to, to ? ERR : bif.read_data} : 33'h0;
      checks++; if ({bif.read, bif.write, bif.address, bif.write_data, bif.option} !== exp_bus) begin
        failures++; $display("FAIL rnd_bus cyc=%0d got=%0h exp=%0h", cyc, {bif.read, bif.write, bif.address, bif.write_data, bif.option}, exp_bus); end
      checks++; if ({bif.m0_response, bif.m0_read_data} !== exp_m[0]) begin
        failures++; $display("FAIL rnd_m0 cyc=%0d got=%0h exp=%0h", cyc, {bif.m0_response, bif.m0_read_data}, exp_m[0]); end
      checks++; if ({bif.m1_response, bif.m1_read_data} !== exp_m[1]) begin
        failures++; $display("FAIL rnd_m1 cyc=%0d got=%0h exp=%0h", cyc, {bif.m1_response, bif.m1_read_data}, exp_m[1]); end
      checks++; if (bif.owner !== 2'(holder)) begin
        failures++; $display("FAIL rnd_owner cyc=%0d got=%0h exp=%0h", cyc, bif.owner, holder); end
      checks++; if (bif.bus_error !== to) begin
        failures++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, bif.bus_error, to); end
      resp_seen = serving && (bif.response || to);
      case (phase)
        0: begin
          if (active[0] && active[1]) holder = prefer;
          else if (active[0])         holder = 1;
          else if (active[1])         holder = 2;
          if (holder != 0) begin phase = 1; age = 0; end
        end
        1: begin
          if (resp_seen) begin prefer = (holder == 1) ? 2 : 1; phase = 2; end
          else if (age < int'(TO)) age++;
        end
        default: begin holder = 0; phase = 0; end
      endcase
      if (resp_seen) begin
        if ($urandom_range(0, 3) == 0) new_txn(hi);
        else active[hi] = 1'b0;
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_timeout_race();
    test_reset_mid_grant();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
